// File: rtl/ttm_sync_pkg.sv
// Shared types and helpers for the pulse-synchronizer arbiter.
package ttm_sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int NREQ_MAX = 8;
    // Index width that covers every legal requester count.
    localparam int ID_W = clog2(NREQ_MAX);

endpackage

// File: rtl/synch_pul_arbiter_rr_pick.sv
// Round-robin selector: first set bit of i_pending at or after i_ptr, wrapping.
module rr_pick
    import ttm_sync_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_pending,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx
);

    int          w_j;
    logic [IW-1:0] w_jx;

    // Scan farthest-first so the candidate closest to the pointer is written last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        w_jx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NREQ) w_j = w_j - NREQ;
            w_jx = IW'(w_j);
            if (i_pending[w_jx]) begin
                o_valid = 1'b1;
                o_idx   = w_jx;
            end
        end
    end

endmodule

// File: rtl/synch_pul_arbiter.sv
// Shares one pulsef/donef synchronizer channel between NREQ fast-domain requesters,
// one buffered event per requester, round-robin grant, one pulse in flight at a time.
module synch_pul_arbiter
    import ttm_sync_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int TMO_W = 10
) (
    input  logic                   ckf,
    input  logic                   resetnf,
    input  logic                   en,
    input  logic [NREQ-1:0]        req_pulse,
    input  logic [NREQ*DW-1:0]     req_data,
    input  logic                   clr_flags,
    output logic [NREQ-1:0]        pending,
    output logic [NREQ-1:0]        ovf,
    output logic                   tmo_err,
    output logic                   sync_pulsef,
    input  logic                   sync_donef,
    output logic [DW-1:0]          xfer_data,
    output logic [clog2(NREQ)-1:0] xfer_id,
    output logic                   busy,
    output state_e                 dbg_state
);

    localparam int IW = clog2(NREQ);

    // Handshake: sync_pulsef is high for exactly one cycle (ISSUE); xfer_data/xfer_id stay
    // stable until sync_donef is seen in WAIT; sync_donef in any other state is ignored.
    state_e            r_state, w_state_nxt;
    logic [NREQ-1:0]   r_pending, r_ovf;
    logic [DW-1:0]     r_buf [NREQ];
    logic              r_tmo_err;
    logic [IW-1:0]     r_ptr, r_xfer_id;
    logic [DW-1:0]     r_xfer_data;
    logic [TMO_W-1:0]  r_tmo_cnt, w_cnt_inc;
    logic              w_pick_valid, w_grant, w_tmo_hit;
    logic [IW-1:0]     w_pick_idx;
    logic [NREQ-1:0]   w_grant_vec, w_capture, w_drop;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_valid   (w_pick_valid),
        .o_idx     (w_pick_idx)
    );

    always_comb begin
        w_grant     = (r_state == ST_IDLE) & en & w_pick_valid;
        w_grant_vec = '0;
        if (w_grant) w_grant_vec[w_pick_idx] = 1'b1;
        // A slot being granted this cycle is free to take a new event.
        w_capture   = req_pulse & (~r_pending | w_grant_vec);
        w_drop      = req_pulse & r_pending & ~w_grant_vec;
        w_cnt_inc   = r_tmo_cnt + TMO_W'(1);
        w_tmo_hit   = (r_state == ST_WAIT) & ~sync_donef & (w_cnt_inc == '1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (sync_donef)     w_state_nxt = ST_GAP;
                else if (w_tmo_hit) w_state_nxt = ST_HALT;
            end
            ST_GAP:   w_state_nxt = ST_IDLE;
            ST_HALT:  if (clr_flags) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ckf or negedge resetnf) begin
        if (!resetnf) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge ckf or negedge resetnf) begin
        if (!resetnf) begin
            r_pending   <= '0;
            r_ovf       <= '0;
            r_tmo_err   <= 1'b0;
            r_ptr       <= '0;
            r_xfer_id   <= '0;
            r_xfer_data <= '0;
            r_tmo_cnt   <= '0;
            for (int i = 0; i < NREQ; i++) r_buf[i] <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant_vec) | w_capture;
            r_ovf     <= (r_ovf & ~{NREQ{clr_flags}}) | w_drop;
            r_tmo_err <= (r_tmo_err & ~clr_flags) | w_tmo_hit;
            for (int i = 0; i < NREQ; i++) begin
                if (w_capture[i]) r_buf[i] <= req_data[i*DW +: DW];
            end
            if (w_grant) begin
                r_xfer_id   <= w_pick_idx;
                r_xfer_data <= r_buf[w_pick_idx];
                r_ptr       <= (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + IW'(1);
            end
            if (r_state == ST_ISSUE)                    r_tmo_cnt <= '0;
            else if (r_state == ST_WAIT && !sync_donef) r_tmo_cnt <= w_cnt_inc;
        end
    end

    assign pending     = r_pending;
    assign ovf         = r_ovf;
    assign tmo_err     = r_tmo_err;
    assign xfer_id     = r_xfer_id;
    assign xfer_data   = r_xfer_data;
    assign sync_pulsef = (r_state == ST_ISSUE);
    assign busy        = (r_state == ST_ISSUE) | (r_state == ST_WAIT);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_synch_pul_arbiter.sv
// Directed bench for synch_pul_arbiter with a cycle-level behavioural reference.
module tb_synch_pul_arbiter;
  import ttm_sync_pkg::*;

  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int TMO_W = 4;
  localparam int IW    = 2;
  localparam int W     = IW + DW;

  logic                 ckf;
  logic                 resetnf = 1'b0;
  logic                 en = 1'b1;
  logic [NREQ-1:0]      req_pulse = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic                 clr_flags = 1'b0;
  logic                 sync_donef = 1'b0;
  logic [NREQ-1:0]      pending, ovf;
  logic                 tmo_err, sync_pulsef, busy;
  logic [DW-1:0]        xfer_data;
  logic [IW-1:0]        xfer_id;
  state_e               dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  synch_pul_arbiter #(.NREQ(NREQ), .DW(DW), .TMO_W(TMO_W)) dut (
    .ckf         (ckf),
    .resetnf     (resetnf),
    .en          (en),
    .req_pulse   (req_pulse),
    .req_data    (req_data),
    .clr_flags   (clr_flags),
    .pending     (pending),
    .ovf         (ovf),
    .tmo_err     (tmo_err),
    .sync_pulsef (sync_pulsef),
    .sync_donef  (sync_donef),
    .xfer_data   (xfer_data),
    .xfer_id     (xfer_id),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial ckf = 1'b0;
  always #5 ckf = ~ckf;

  // ---------------- reference model ----------------
  typedef enum int {M_FREE, M_PULSE, M_WAITING, M_COOL, M_STUCK} mphase_e;
  mphase_e         m_phase;
  logic [NREQ-1:0] m_pend, m_ovf;
  logic [DW-1:0]   m_buf [NREQ];
  logic            m_tmo;
  int              m_ptr, m_xid, m_waited;
  logic [DW-1:0]   m_xdata;
  logic [W-1:0]    exp_q[$];
  bit              g_grant, g_tmo;
  int              g_id;
  logic [NREQ-1:0] g_drop;

  always @(posedge ckf or negedge resetnf) begin
    if (!resetnf) begin
      m_phase = M_FREE; m_pend = '0; m_ovf = '0; m_tmo = 1'b0;
      m_ptr = 0; m_xid = 0; m_xdata = '0; m_waited = 0;
      for (int i = 0; i < NREQ; i++) m_buf[i] = '0;
      exp_q.delete();
    end else begin
      g_grant = 1'b0; g_id = 0; g_drop = '0; g_tmo = 1'b0;
      if (m_phase == M_FREE && en) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!g_grant && m_pend[(m_ptr + k) % NREQ]) begin
            g_grant = 1'b1;
            g_id = (m_ptr + k) % NREQ;
          end
        end
      end
      if (g_grant) begin
        m_xid = g_id;
        m_xdata = m_buf[g_id];
        exp_q.push_back({IW'(g_id), m_buf[g_id]});
        m_ptr = (g_id + 1) % NREQ;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_pulse[i]) begin
          if (!m_pend[i] || (g_grant && g_id == i)) begin
            m_pend[i] = 1'b1;
            m_buf[i] = req_data[i*DW +: DW];
          end else begin
            g_drop[i] = 1'b1;
          end
        end else if (g_grant && g_id == i) begin
          m_pend[i] = 1'b0;
        end
      end
      case (m_phase)
        M_FREE:    if (g_grant) m_phase = M_PULSE;
        M_PULSE:   begin m_phase = M_WAITING; m_waited = 0; end
        M_WAITING: begin
          if (sync_donef) m_phase = M_COOL;
          else begin
            m_waited++;
            if (m_waited == (1 << TMO_W) - 1) begin m_phase = M_STUCK; g_tmo = 1'b1; end
          end
        end
        M_COOL:    m_phase = M_FREE;
        M_STUCK:   if (clr_flags) m_phase = M_FREE;
        default:   m_phase = M_FREE;
      endcase
      m_ovf = (clr_flags ? '0 : m_ovf) | g_drop;
      m_tmo = (m_tmo && !clr_flags) || g_tmo;
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process + scoreboard ----------------
  logic [W-1:0] sb_e;
  always @(negedge ckf) begin
    if (resetnf) begin
      chk("pending", 32'(pending), 32'(m_pend));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("tmo_err", 32'(tmo_err), 32'(m_tmo));
      chk("sync_pulsef", 32'(sync_pulsef), 32'(m_phase == M_PULSE));
      chk("busy", 32'(busy), 32'(m_phase == M_PULSE || m_phase == M_WAITING));
      chk("xfer_id", 32'(xfer_id), 32'(m_xid));
      chk("xfer_data", 32'(xfer_data), 32'(m_xdata));
      if (sync_pulsef) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL sb_unexpected_pulse id=%0d data=%0h", xfer_id, xfer_data);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_xfer", 32'({xfer_id, xfer_data}), 32'(sb_e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge ckf);
  endtask

  task automatic do_reset();
    resetnf = 1'b0;
    repeat (2) tick();
    resetnf = 1'b1;
    tick();
  endtask

  // Pulses requesters in mask; slice i carries d + i.
  task automatic fire(input logic [NREQ-1:0] mask, input logic [DW-1:0] d);
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = d + DW'(i);
    req_pulse = mask;
    tick();
    req_pulse = '0;
  endtask

  task automatic wait_pulse(input int id, input logic [DW-1:0] d, output int lat);
    lat = 0;
    while (sync_pulsef !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    if (lat >= 50) begin
      n_checks++; n_errors++;
      $display("FAIL pulse_wait no sync_pulsef within 50 cycles, expected id=%0d", id);
    end else begin
      chk("lit_xfer_id", 32'(xfer_id), 32'(id));
      chk("lit_xfer_data", 32'(xfer_data), 32'(d));
    end
  endtask

  task automatic send_done(input int dly);
    repeat (dly) tick();
    sync_donef = 1'b1;
    tick();
    sync_donef = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int lat, w, k, p0;
  initial begin
    repeat (2) tick();
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_tmo", 32'(tmo_err), 0);
    chk("rst_pulse", 32'(sync_pulsef), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_id", 32'(xfer_id), 0);
    chk("rst_data", 32'(xfer_data), 0);
    resetnf = 1'b1;
    tick();

    // single event on requester 2
    fire(4'b0100, 16'hA5A3);
    wait_pulse(2, 16'hA5A5, lat);
    chk("single_latency", 32'(lat + 1), 2);
    send_done(6);
    chk("gap_busy_low", 32'(busy), 0);
    tick();
    chk("idle_no_pulse", 32'(sync_pulsef), 0);

    // round-robin from pointer 0
    do_reset();
    fire(4'b1011, 16'h1000);
    wait_pulse(0, 16'h1000, lat); send_done(2);
    wait_pulse(1, 16'h1001, lat); send_done(2);
    wait_pulse(3, 16'h1003, lat); send_done(2);
    fire(4'b1001, 16'h2000);
    wait_pulse(0, 16'h2000, lat); send_done(2);
    wait_pulse(3, 16'h2003, lat); send_done(2);

    // overflow behind an active transfer
    fire(4'b0001, 16'h3000);
    wait_pulse(0, 16'h3000, lat);
    fire(4'b0010, 16'h4000);
    fire(4'b0010, 16'h5000);
    chk("ovf_set", 32'(ovf), 32'h2);
    chk("ovf_pending", 32'(pending), 32'h2);
    send_done(2);
    wait_pulse(1, 16'h4001, lat); send_done(2);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);

    // grant and new pulse on requester 0 in the same cycle
    en = 1'b0;
    fire(4'b0001, 16'h6000);
    tick();
    chk("held_pending", 32'(pending), 32'h1);
    en = 1'b1;
    fire(4'b0001, 16'h7000);
    chk("same_cycle_pending", 32'(pending), 32'h1);
    chk("same_cycle_ovf", 32'(ovf), 0);
    wait_pulse(0, 16'h6000, lat); send_done(2);
    wait_pulse(0, 16'h7000, lat); send_done(2);

    // en dropped during WAIT: transfer completes, then nothing new
    fire(4'b0100, 16'h8000);
    wait_pulse(2, 16'h8002, lat);
    en = 1'b0;
    fire(4'b0001, 16'h9000);
    send_done(2);
    p0 = n_pulses;
    repeat (6) tick();
    chk("en0_no_pulse", 32'(n_pulses), 32'(p0));
    chk("en0_pending", 32'(pending), 32'h1);
    en = 1'b1;
    wait_pulse(0, 16'h9000, lat); send_done(2);

    // timeout with no donef
    fire(4'b1000, 16'hA000);
    wait_pulse(3, 16'hA003, lat);
    w = 0; k = 0;
    while (!tmo_err && k < 40) begin
      tick(); k++;
      if (busy) w++;
    end
    chk("tmo_wait_cycles", 32'(w), 15);
    chk("tmo_flag", 32'(tmo_err), 1);
    chk("halt_busy", 32'(busy), 0);
    p0 = n_pulses;
    fire(4'b0010, 16'hB000);
    repeat (4) tick();
    chk("halt_no_pulse", 32'(n_pulses), 32'(p0));
    chk("halt_pending", 32'(pending), 32'h2);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("tmo_cleared", 32'(tmo_err), 0);
    wait_pulse(1, 16'hB001, lat); send_done(2);
    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 0);

    // async reset while waiting for donef
    fire(4'b0100, 16'hC000);
    wait_pulse(2, 16'hC002, lat);
    fire(4'b0001, 16'hD000);
    tick();
    #2 resetnf = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pulse", 32'(sync_pulsef), 0);
    chk("arst_pending", 32'(pending), 0);
    chk("arst_id", 32'(xfer_id), 0);
    chk("arst_data", 32'(xfer_data), 0);
    tick();
    #2 resetnf = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
